perm_issue_ctrl: RTL
====================

# perm_issue_ctrl

Issue controller and RAW scoreboard for the odd-pipe Permute unit. It sits between decode/register-fetch and the Permute datapath. It accepts one decoded instruction per cycle over a valid/ready handshake and stalls any instruction whose source register is still in flight in Permute's 4-stage delay line. When an instruction is held, the controller drives a nop (format 0, op 0) into the unit. It also flags operand forwarding from Permute's writeback output and keeps saturating issue and stall counters.

## Interface
- `LATENCY`, default 4: Permute result latency in cycles (issue to `rt_wb` valid). Must be ≥ 2.
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  controller accepts the instruction this cycle
- `in_op`  in  [0:10]  decoded opcode
- `in_format`  in  [2:0]  instruction format
- `in_rt_addr`  in  [0:6]  destination register
- `in_reg_write`  in  1  instruction writes the register file
- `in_ra_addr`, `in_rb_addr`  in  [0:6] each  source register addresses
- `in_uses_ra`, `in_uses_rb`  in  1 each  source operand is actually read
- `perm_op`  out  [0:10]  to Permute `op`
- `perm_format`  out  [2:0]  to Permute `format`
- `perm_rt_addr`  out  [0:6]  to Permute `rt_addr`
- `perm_reg_write`  out  1  to Permute `reg_write`
- `fwd_ra`, `fwd_rb`  out  1 each  take this operand from Permute `rt_wb`, not from the register file
- `busy`  out  1  at least one scoreboard slot is valid
- `issue_cnt`  out  CNT_W  instructions issued
- `stall_cnt`  out  CNT_W  cycles with `in_valid` high and `in_ready` low

## Operation
**Scoreboard**
- Slots 1..LATENCY, each holding {v, addr[0:6]}. Slot k is the instruction issued k cycles ago.
- Slot LATENCY aligns with Permute's writeback stage.

**Hazard**
- `hz_a` = `in_uses_ra` and some slot k in 1..LATENCY-1 has v=1 and addr=`in_ra_addr`.
- `hz_b` is the same check for rb.
- `in_ready` = !reset and !(`hz_a` or `hz_b`). It is combinational and does not depend on `in_valid`.

**Issue**
- `issue` = `in_valid` and `in_ready`.
- When `issue` is high, the `perm_*` outputs pass the `in_*` fields through combinationally.
- When `issue` is low, the `perm_*` outputs are all zero (nop).

**Forwarding**
- `fwd_ra` = `issue` and `in_uses_ra` and slot LATENCY v=1 and addr=`in_ra_addr`. `fwd_rb` follows the same rule.
- Forwarding from slot LATENCY never stalls.

**Slot update at each posedge**
- slot1 ← {`issue` and `in_reg_write`, `in_rt_addr`}.
- slot k+1 ← slot k.
- Slot LATENCY falls off the end.
- A nop instruction (format 0, op 0) or one with `reg_write`=0 issues but creates no valid entry.

**Counters**
- `issue_cnt` increments on `issue`.
- `stall_cnt` increments when `in_valid` and !`in_ready`.
- Both saturate at all-ones and never wrap.

**Other rules**
- `busy` is the OR of all slot v bits.
- There is no WAW or structural check: the pipe is single, in order and fixed latency.
- Register 0 gets no special handling.

## Timing
- Reset values: all slots v=0 and addr=0, both counters 0, `busy`=0.
- While `reset` is high: `in_ready`=0, `perm_*` outputs = 0, `fwd_*`=0.
- Reset mid-operation clears all slots in one cycle. Permute is reset on the same signal, so the two stay aligned.
- Producer issued in cycle t lands in slot k during cycle t+k.
- A dependent consumer stalls during t+1 .. t+LATENCY-1.
- The consumer issues in t+LATENCY with `fwd_*`=1.
- Minimum dependent spacing is LATENCY cycles, and each such pair adds LATENCY-1 to `stall_cnt`.
- Independent instructions issue every cycle.
- When ra and rb both hit, the hazard clears only once both producers reach slot ≥ LATENCY.
- If ra hits slot LATENCY while rb hits an earlier slot, the instruction stalls and `fwd_ra` is 0 that cycle.
- Multiple slots may hold the same addr (WAW in flight). The hazard persists while any matching slot is below LATENCY.
- Forwarding selects the slot LATENCY entry, which is the oldest.

## Structure
- Shared package `spu_pkg`:
  - `REG_ADDR_W`=7, `OP_W`=11, `FMT_W`=3
  - `NOP_OP`=0, `NOP_FMT`=0
  - typedef `sb_slot_t` {logic v; logic [0:6] addr}
- One sub-module, `reg_scoreboard`:
  - holds the slot shift register
  - outputs per-source `hit_early` and `hit_wb`
  - is reused for the even pipe later with its own LATENCY
- The top level holds the handshake, nop insertion and counters.

## Test plan
- **Reset mid-stream:** reset asserted while slots are full → next cycle `busy`=0, counters 0, `in_ready`=1 after reset drops, `perm_*` outputs = 0 during reset.
- **Independent stream:** 10 instructions with no dependencies (rt=1..10, ra/rb=100) → issue every cycle, `issue_cnt`=10, `stall_cnt`=0.
- **Back-to-back RAW:** shlqbi rt=5, then ra=5 next cycle → `in_ready`=0 for 3 cycles, issues in cycle t+4 with `fwd_ra`=1, `stall_cnt`=3, Permute's `rt_wb` holds the producer result in that cycle.
- **Dual source:** producer rt=7 at t, producer rt=9 at t+1, consumer ra=7 rb=9 → issues at t+5 with `fwd_rb`=1 and `fwd_ra`=0.
- **Nop and no-write producer:** producer with `reg_write`=0 and rt=3, or a nop, followed by consumer ra=3 → no stall, `busy` stays 0.
- **Counter saturation:** with `CNT_W`=4, hold a hazard for 20 cycles → `stall_cnt` stays at 15.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared SPU issue-side definitions: field widths, nop encoding and scoreboard slot layout.
package spu_pkg;
   localparam int REG_ADDR_W = 7;
   localparam int OP_W       = 11;
   localparam int FMT_W      = 3;

   localparam logic [0:OP_W-1]  NOP_OP  = '0;
   localparam logic [FMT_W-1:0] NOP_FMT = '0;

   typedef struct packed {
      logic                  v;
      logic [0:REG_ADDR_W-1] addr;
   } sb_slot_t;
endpackage

// File: rtl/perm_issue_ctrl_if.sv
// Decode/register-fetch to issue controller handshake bundle.
interface perm_issue_ctrl_if;
   import spu_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [0:OP_W-1]       in_op;
   logic [FMT_W-1:0]      in_format;
   logic [0:REG_ADDR_W-1] in_rt_addr;
   logic                  in_reg_write;
   logic [0:REG_ADDR_W-1] in_ra_addr;
   logic [0:REG_ADDR_W-1] in_rb_addr;
   logic                  in_uses_ra;
   logic                  in_uses_rb;

   modport master (
      output in_valid, in_op, in_format, in_rt_addr, in_reg_write,
             in_ra_addr, in_rb_addr, in_uses_ra, in_uses_rb,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_format, in_rt_addr, in_reg_write,
             in_ra_addr, in_rb_addr, in_uses_ra, in_uses_rb,
      output in_ready
   );
endinterface

// File: rtl/perm_issue_ctrl_scoreboard.sv
// Fixed-latency RAW scoreboard: shift register of in-flight destinations, matched per source.
module reg_scoreboard
   import spu_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int NSRC    = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                wr_v,
   input  logic [0:REG_ADDR_W-1]               wr_addr,
   input  logic [NSRC-1:0][0:REG_ADDR_W-1]     src_addr,
   output logic [NSRC-1:0]                     hit_early,
   output logic [NSRC-1:0]                     hit_wb,
   output logic                                busy
);

   sb_slot_t slot [1:LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= LATENCY; k++) slot[k] <= '0;
      end else begin
         slot[1] <= '{v: wr_v, addr: wr_addr};
         for (int k = 2; k <= LATENCY; k++) slot[k] <= slot[k-1];
      end
   end

   // Slots below LATENCY are not yet on rt_wb and must stall; slot LATENCY forwards.
   always_comb begin
      hit_early = '0;
      hit_wb    = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int k = 1; k < LATENCY; k++)
            if (slot[k].v && slot[k].addr == src_addr[i]) hit_early[i] = 1'b1;
         hit_wb[i] = slot[LATENCY].v && slot[LATENCY].addr == src_addr[i];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 1; k <= LATENCY; k++) busy = busy | slot[k].v;
   end

endmodule

// File: rtl/perm_issue_ctrl.sv
// Permute issue controller: RAW stall, nop insertion, wb forwarding flags and perf counters.
module perm_issue_ctrl
   import spu_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   perm_issue_ctrl_if.slave      dec,
   output logic [0:OP_W-1]       perm_op,
   output logic [FMT_W-1:0]      perm_format,
   output logic [0:REG_ADDR_W-1] perm_rt_addr,
   output logic                  perm_reg_write,
   output logic                  fwd_ra,
   output logic                  fwd_rb,
   output logic                  busy,
   output logic [CNT_W-1:0]      issue_cnt,
   output logic [CNT_W-1:0]      stall_cnt
);

   logic [1:0][0:REG_ADDR_W-1] src_addr;
   logic [1:0]                 hit_early, hit_wb;
   logic                       hz_a, hz_b, issue, is_nop, wr_v;

   assign src_addr = {dec.in_rb_addr, dec.in_ra_addr};

   reg_scoreboard #(.LATENCY(LATENCY), .NSRC(2)) u_sb (
      .clk       (clk),
      .reset     (reset),
      .wr_v      (wr_v),
      .wr_addr   (dec.in_rt_addr),
      .src_addr  (src_addr),
      .hit_early (hit_early),
      .hit_wb    (hit_wb),
      .busy      (busy)
   );

   assign hz_a         = dec.in_uses_ra && hit_early[0];
   assign hz_b         = dec.in_uses_rb && hit_early[1];
   assign dec.in_ready = !reset && !(hz_a || hz_b);
   assign issue        = dec.in_valid && dec.in_ready;
   assign is_nop       = dec.in_op == NOP_OP && dec.in_format == NOP_FMT;
   assign wr_v         = issue && dec.in_reg_write && !is_nop;

   // A held instruction presents a nop to Permute so its pipe keeps marching.
   assign perm_op        = issue ? dec.in_op        : NOP_OP;
   assign perm_format    = issue ? dec.in_format    : NOP_FMT;
   assign perm_rt_addr   = issue ? dec.in_rt_addr   : '0;
   assign perm_reg_write = issue && dec.in_reg_write;

   assign fwd_ra = issue && dec.in_uses_ra && hit_wb[0];
   assign fwd_rb = issue && dec.in_uses_rb && hit_wb[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (issue && issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
         if (dec.in_valid && !dec.in_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
